// File: rtl/tennis_pkg.sv
// Shared types and constants for the rally referee and its per-side hit window timers.
package tennis_pkg;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        RALLY = 2'd1,
        POINT = 2'd2,
        OVER  = 2'd3
    } ref_state_e;

    localparam logic SIDE_ONE = 1'b0;
    localparam logic SIDE_TWO = 1'b1;

    localparam int              TIMER_W            = 25;
    localparam logic [TIMER_W-1:0] DEFAULT_HIT_WINDOW = 25'd12_000_000;

endpackage

// File: rtl/hit_window_timer.sv
// One side's swing window: loads on hittable rise, counts down while the ball is owed a return,
// and flags a valid return or a miss (timeout or ball leaving unreturned) for the referee.
module hit_window_timer
    import tennis_pkg::*;
#(
    parameter logic [TIMER_W-1:0] HIT_WINDOW = DEFAULT_HIT_WINDOW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic hittable,
    input  logic button,
    output logic return_ok,
    output logic miss
);

    logic               hittable_q, hittable_d;
    logic               returned_q, returned_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    logic               rise;
    logic               fall;
    logic               returned_eff;
    logic [TIMER_W-1:0] timer_eff;
    logic               expired;

    always_comb begin
        rise         = hittable & ~hittable_q;
        fall         = ~hittable & hittable_q;
        // On the rise cycle the window is already open even though the registers load next edge.
        timer_eff    = rise ? HIT_WINDOW : timer_q;
        returned_eff = rise ? 1'b0 : returned_q;

        return_ok = enable & hittable & button & ~returned_eff & (timer_eff != '0);
        // A swing in the last counting cycle beats the timeout.
        expired   = hittable & ~returned_eff & ~return_ok & (timer_eff <= TIMER_W'(1));
        miss      = enable & (expired | (fall & ~returned_q));

        hittable_d = hittable;
        timer_d    = timer_eff;
        returned_d = returned_eff;
        if (!enable) begin
            // Outside a rally nothing is owed, so a ball already sitting at this end is never judged.
            timer_d    = '0;
            returned_d = 1'b1;
        end else if (return_ok) begin
            returned_d = 1'b1;
        end else if (hittable && !returned_eff && (timer_eff != '0)) begin
            timer_d = timer_eff - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hittable_q <= 1'b0;
            returned_q <= 1'b0;
            timer_q    <= '0;
        end else begin
            hittable_q <= hittable_d;
            returned_q <= returned_d;
            timer_q    <= timer_d;
        end
    end

endmodule

// File: rtl/rally_referee.sv
// Rally referee: judges swings and misses during play, pulses returns/points to the ball block, keeps score.
// Build option: EARLY_SWING_FAULT_EN makes a swing with the ball at neither end a fault against the swinger.
module rally_referee
    import tennis_pkg::*;
#(
    parameter logic [TIMER_W-1:0] HIT_WINDOW = DEFAULT_HIT_WINDOW,
    parameter int                 WIN_POINTS = 7,
    parameter int                 SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               button_one,
    input  logic               button_two,
    input  logic               hittable_one,
    input  logic               hittable_two,
    input  logic               start_game,
    output logic               return_one,
    output logic               return_two,
    output logic               match_one,
    output logic               match_two,
    output logic [SCORE_W-1:0] score_one,
    output logic [SCORE_W-1:0] score_two,
    output logic               game_over,
    output logic               winner
);

    localparam logic [SCORE_W-1:0] WIN_SC = SCORE_W'(WIN_POINTS);

    ref_state_e         state_q, state_d;
    logic               scorer_q, scorer_d;
    logic [SCORE_W-1:0] score_one_q, score_one_d;
    logic [SCORE_W-1:0] score_two_q, score_two_d;
    logic               return_one_q, return_one_d;
    logic               return_two_q, return_two_d;
    logic               match_one_q, match_one_d;
    logic               match_two_q, match_two_d;
    logic               game_over_q, game_over_d;
    logic               winner_q, winner_d;

    logic in_rally;
    logic ok_one, ok_two;
    logic miss_one, miss_two;
    logic fault_one, fault_two;
    logic lose_one, lose_two;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= WIN_SC) ? s : s + SCORE_W'(1);
    endfunction

    assign in_rally = (state_q == RALLY);

    hit_window_timer #(.HIT_WINDOW(HIT_WINDOW)) u_timer_one (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (in_rally),
        .hittable  (hittable_one),
        .button    (button_one),
        .return_ok (ok_one),
        .miss      (miss_one)
    );

    hit_window_timer #(.HIT_WINDOW(HIT_WINDOW)) u_timer_two (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (in_rally),
        .hittable  (hittable_two),
        .button    (button_two),
        .return_ok (ok_two),
        .miss      (miss_two)
    );

`ifdef EARLY_SWING_FAULT_EN
    assign fault_one = in_rally & button_one & ~hittable_one & ~hittable_two;
    assign fault_two = in_rally & button_two & ~hittable_two & ~hittable_one;
`else
    assign fault_one = 1'b0;
    assign fault_two = 1'b0;
`endif

    assign lose_one = miss_one | fault_one;
    assign lose_two = miss_two | fault_two;

    always_comb begin
        state_d      = state_q;
        scorer_d     = scorer_q;
        score_one_d  = score_one_q;
        score_two_d  = score_two_q;
        return_one_d = 1'b0;
        return_two_d = 1'b0;
        match_one_d  = 1'b0;
        match_two_d  = 1'b0;
        game_over_d  = game_over_q;
        winner_d     = winner_q;

        case (state_q)
            SERVE: begin
                if (start_game) begin
                    state_d = RALLY;
                end
            end
            RALLY: begin
                return_one_d = ok_one;
                return_two_d = ok_two;
                // Match pulse and score bump are registered together so both appear in the POINT cycle.
                if (lose_one) begin
                    state_d     = POINT;
                    scorer_d    = SIDE_TWO;
                    match_two_d = 1'b1;
                    score_two_d = sat_inc(score_two_q);
                end else if (lose_two) begin
                    state_d     = POINT;
                    scorer_d    = SIDE_ONE;
                    match_one_d = 1'b1;
                    score_one_d = sat_inc(score_one_q);
                end
            end
            POINT: begin
                if (((scorer_q == SIDE_ONE) ? score_one_q : score_two_q) == WIN_SC) begin
                    state_d     = OVER;
                    game_over_d = 1'b1;
                    winner_d    = scorer_q;
                end else begin
                    state_d = SERVE;
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = SERVE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SERVE;
            scorer_q     <= SIDE_ONE;
            score_one_q  <= '0;
            score_two_q  <= '0;
            return_one_q <= 1'b0;
            return_two_q <= 1'b0;
            match_one_q  <= 1'b0;
            match_two_q  <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            scorer_q     <= scorer_d;
            score_one_q  <= score_one_d;
            score_two_q  <= score_two_d;
            return_one_q <= return_one_d;
            return_two_q <= return_two_d;
            match_one_q  <= match_one_d;
            match_two_q  <= match_two_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
        end
    end

    assign return_one = return_one_q;
    assign return_two = return_two_q;
    assign match_one  = match_one_q;
    assign match_two  = match_two_q;
    assign score_one  = score_one_q;
    assign score_two  = score_two_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule
